// File: rtl/dsi_hs_lane_rx.sv
// dsi_hs_lane_rx: D-PHY HS receive lane that finds the sync byte at any bit offset and realigns payload bytes
module dsi_hs_lane_rx #(
  parameter logic [7:0] SYNC_BYTE = 8'b00011101
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] hs_input,
  input  logic       hs_active,
  input  logic [7:0] hs_settle_timeout,
  input  logic [7:0] hs_sync_timeout,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_active,
  output logic       rx_start,
  output logic       rx_done,
  output logic       err_sync,
  output logic [2:0] align_offset
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SETTLE   = 3'd1;
  localparam logic [2:0] SEARCH   = 3'd2;
  localparam logic [2:0] ACTIVE   = 3'd3;
  localparam logic [2:0] WAIT_END = 3'd4;
  logic [2:0]  state;
  logic [7:0]  prev_byte;
  logic [7:0]  cnt;
  logic        armed;
  logic [15:0] w;
  logic        hit;
  logic [2:0]  hit_k;
  logic [7:0]  aligned;
  logic [7:0]  settle_load;
  assign w           = {hs_input, prev_byte};
  assign aligned     = w[align_offset +: 8];
  assign settle_load = hs_settle_timeout == 8'd0 ? 8'd1 : hs_settle_timeout;
  assign rx_active   = state == ACTIVE;
  // At most one offset can match, so the offsets are simply OR-merged
  always_comb begin
    hit   = 1'b0;
    hit_k = 3'd0;
    for (int i = 0; i < 8; i++)
      if (w[i +: 8] == SYNC_BYTE && (w & ((16'd1 << i) - 16'd1)) == 16'd0) begin
        hit   = 1'b1;
        hit_k = hit_k | 3'(i);
      end
  end
  // armed records a low hs_active last cycle, so a burst only starts on a fresh HS entry
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      prev_byte    <= 8'd0;
      cnt          <= 8'd0;
      armed        <= 1'b0;
      rx_data      <= 8'd0;
      rx_valid     <= 1'b0;
      rx_start     <= 1'b0;
      rx_done      <= 1'b0;
      err_sync     <= 1'b0;
      align_offset <= 3'd0;
    end else begin
      armed     <= ~hs_active;
      prev_byte <= state == IDLE ? 8'd0 : hs_input;
      rx_valid  <= 1'b0;
      rx_start  <= 1'b0;
      rx_done   <= 1'b0;
      err_sync  <= 1'b0;
      if (state != IDLE && !hs_active) begin
        state   <= IDLE;
        rx_done <= state == ACTIVE;
      end else begin
        case (state)
          IDLE:
            if (hs_active && armed) begin
              state <= SETTLE;
              cnt   <= settle_load;
            end
          SETTLE:
            if (cnt == 8'd1) begin
              state <= SEARCH;
              cnt   <= hs_sync_timeout;
            end else cnt <= cnt - 8'd1;
          SEARCH:
            if (hit) begin
              state        <= ACTIVE;
              align_offset <= hit_k;
              rx_start     <= 1'b1;
            end else if (cnt == 8'd1) begin
              state    <= WAIT_END;
              err_sync <= 1'b1;
            end else if (cnt != 8'd0) cnt <= cnt - 8'd1;
          ACTIVE: begin
            rx_data  <= aligned;
            rx_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_dsi_hs_lane_rx.sv
// tb_dsi_hs_lane_rx: randomized and directed bursts checked against a per-burst reference model
module tb_dsi_hs_lane_rx;
  localparam logic [7:0] SYNC = 8'h1D;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] hs_input;
  logic       hs_active;
  logic [7:0] hs_settle_timeout;
  logic [7:0] hs_sync_timeout;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_active;
  logic       rx_start;
  logic       rx_done;
  logic       err_sync;
  logic [2:0] align_offset;
  int checks = 0;
  int fails = 0;
  int total;
  logic [7:0]  b     [0:63];
  logic [15:0] exp_v [0:99];
  logic [15:0] obs_v [0:99];

  dsi_hs_lane_rx dut (
    .clk(clk), .rst(rst), .hs_input(hs_input), .hs_active(hs_active),
    .hs_settle_timeout(hs_settle_timeout), .hs_sync_timeout(hs_sync_timeout),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_active(rx_active), .rx_start(rx_start),
    .rx_done(rx_done), .err_sync(err_sync), .align_offset(align_offset)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // Bits: [15]=valid [14:7]=data [6]=active [5]=start [4]=done [3]=err [2:0]=offset
  function automatic logic [15:0] pack(input logic v, input logic [7:0] d, input logic a,
                                       input logic s, input logic dn, input logic e,
                                       input logic [2:0] off);
    return {v, v ? d : 8'h00, a, s, dn, e, a ? off : 3'd0};
  endfunction

  function automatic int find_k(input logic [7:0] prev, input logic [7:0] cur);
    logic [15:0] w;
    w = {cur, prev};
    for (int k = 0; k < 8; k++)
      if (((w >> k) & 16'h00FF) == {8'h00, SYNC} && (w & ((16'd1 << k) - 16'd1)) == 16'd0) return k;
    return -1;
  endfunction

  task automatic load_bytes(input logic [127:0] s, input int n);
    for (int i = 0; i < n; i++) b[i] = s[8*n-1-8*i -: 8];
  endtask

  // Byte i of the burst is seen in cycle i; settle covers cycles 1..N, search starts at N+1
  task automatic model(input int n, input int t, input int l);
    int ne, lock, k;
    logic [15:0] wv;
    ne = n == 0 ? 1 : n;
    lock = -1;
    k = 0;
    for (int c = 0; c < total; c++) exp_v[c] = 16'h0000;
    for (int i = ne + 1; i < l; i++) begin
      if (t != 0 && i > ne + t) break;
      k = find_k(b[i-1], b[i]);
      if (k >= 0) begin
        lock = i;
        break;
      end
    end
    if (lock >= 0) begin
      for (int c = lock + 1; c <= l; c++) begin
        wv = (c >= lock + 2) ? ({b[c-1], b[c-2]} >> k) : 16'h0000;
        exp_v[c] = pack(c >= lock + 2, wv[7:0], 1'b1, c == lock + 1, 1'b0, 1'b0, 3'(k));
      end
      exp_v[l+1] = pack(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
    end else if (t != 0 && ne + t < l) begin
      exp_v[ne+t+1] = pack(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    end
  endtask

  task automatic run_burst(input int n, input int t, input int l, input int tail);
    total = l + tail;
    hs_settle_timeout = 8'(n);
    hs_sync_timeout = 8'(t);
    repeat (2) begin
      @(posedge clk); #1;
      hs_active = 1'b0;
      hs_input = 8'($urandom);
    end
    for (int c = 0; c < total; c++) begin
      @(posedge clk); #1;
      hs_active = c < l;
      hs_input = c < l ? b[c] : 8'($urandom);
      @(negedge clk);
      obs_v[c] = pack(rx_valid, rx_data, rx_active, rx_start, rx_done, err_sync, align_offset);
    end
    model(n, t, l);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    hs_active = 1'b0;
    hs_input = 8'h00;
    hs_settle_timeout = 8'd2;
    hs_sync_timeout = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rx_data, rx_valid, rx_active, rx_start, rx_done, err_sync, align_offset} !== 16'h0000) begin
      fails++;
      $display("FAIL reset: got %h required 0000",
               {rx_data, rx_valid, rx_active, rx_start, rx_done, err_sync, align_offset});
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_offset0;
    load_bytes(128'h00_00_00_1D_A5_3C_00, 7);
    run_burst(2, 0, 7, 5);
    for (int c = 0; c < total; c++) begin
      checks++;
      if (obs_v[c] !== exp_v[c]) begin
        fails++;
        $display("FAIL offset0 cycle %0d: got %h expected %h", c, obs_v[c], exp_v[c]);
      end
    end
    checks++;
    if (obs_v[5] !== pack(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0)) begin
      fails++;
      $display("FAIL offset0_start: got %h required %h", obs_v[5], pack(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0));
    end
    checks++;
    if (obs_v[6] !== pack(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0)) begin
      fails++;
      $display("FAIL offset0_first: got %h required %h", obs_v[6], pack(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0));
    end
    checks++;
    if (obs_v[7] !== pack(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0)) begin
      fails++;
      $display("FAIL offset0_second: got %h required %h", obs_v[7], pack(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0));
    end
  endtask

  task automatic test_offset3;
    load_bytes(128'h00_00_E8_28_05_00, 6);
    run_burst(2, 0, 6, 5);
    for (int c = 0; c < total; c++) begin
      checks++;
      if (obs_v[c] !== exp_v[c]) begin
        fails++;
        $display("FAIL offset3 cycle %0d: got %h expected %h", c, obs_v[c], exp_v[c]);
      end
    end
    checks++;
    if (obs_v[4] !== pack(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3)) begin
      fails++;
      $display("FAIL offset3_lock: got %h required %h", obs_v[4], pack(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3));
    end
    checks++;
    if (obs_v[5] !== pack(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3)) begin
      fails++;
      $display("FAIL offset3_first: got %h required %h", obs_v[5], pack(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3));
    end
    checks++;
    if (obs_v[6] !== pack(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3)) begin
      fails++;
      $display("FAIL offset3_second: got %h required %h", obs_v[6], pack(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3));
    end
  endtask

  task automatic test_settle_mask;
    load_bytes(128'h00_1D_00_00_00_00_00_1D_A5_00_00, 11);
    run_burst(4, 0, 11, 4);
    for (int c = 0; c < total; c++) begin
      checks++;
      if (obs_v[c] !== exp_v[c]) begin
        fails++;
        $display("FAIL settle_mask cycle %0d: got %h expected %h", c, obs_v[c], exp_v[c]);
      end
    end
    checks++;
    if (obs_v[9] !== pack(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0)) begin
      fails++;
      $display("FAIL settle_mask_lock: got %h required %h", obs_v[9], pack(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0));
    end
    checks++;
    if (obs_v[10] !== pack(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0)) begin
      fails++;
      $display("FAIL settle_mask_data: got %h required %h", obs_v[10], pack(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0));
    end
  endtask

  task automatic test_sync_timeout;
    int errs, vals, dones;
    errs = 0;
    vals = 0;
    dones = 0;
    for (int i = 0; i < 12; i++) b[i] = 8'h00;
    run_burst(2, 4, 12, 4);
    for (int c = 0; c < total; c++) begin
      checks++;
      if (obs_v[c] !== exp_v[c]) begin
        fails++;
        $display("FAIL sync_timeout cycle %0d: got %h expected %h", c, obs_v[c], exp_v[c]);
      end
      errs += int'(obs_v[c][3]);
      vals += int'(obs_v[c][15]);
      dones += int'(obs_v[c][4]);
    end
    checks++;
    if (obs_v[7] !== pack(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0)) begin
      fails++;
      $display("FAIL sync_timeout_err: got %h required %h", obs_v[7], pack(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0));
    end
    checks++;
    if (errs != 1 || vals != 0 || dones != 0) begin
      fails++;
      $display("FAIL sync_timeout_counts: got err=%0d valid=%0d done=%0d required 1 0 0", errs, vals, dones);
    end
  endtask

  task automatic test_back_to_back;
    load_bytes(128'h00_00_00_1D_11_22_33, 7);
    run_burst(1, 0, 7, 4);
    for (int c = 0; c < total; c++) begin
      checks++;
      if (obs_v[c] !== exp_v[c]) begin
        fails++;
        $display("FAIL burst_end cycle %0d: got %h expected %h", c, obs_v[c], exp_v[c]);
      end
    end
    checks++;
    if (obs_v[8] !== pack(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0) || obs_v[9][4] !== 1'b0) begin
      fails++;
      $display("FAIL burst_end_done: got %h,%h required done only in cycle 8", obs_v[8], obs_v[9]);
    end
    load_bytes(128'h00_00_00_A0_03_5A_C3_00, 8);
    run_burst(1, 0, 8, 4);
    for (int c = 0; c < total; c++) begin
      checks++;
      if (obs_v[c] !== exp_v[c]) begin
        fails++;
        $display("FAIL reentry cycle %0d: got %h expected %h", c, obs_v[c], exp_v[c]);
      end
    end
    checks++;
    if (obs_v[5] !== pack(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 3'd5)) begin
      fails++;
      $display("FAIL reentry_lock: got %h required %h", obs_v[5], pack(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 3'd5));
    end
    checks++;
    if (obs_v[6] !== pack(1'b1, 8'hD0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5)) begin
      fails++;
      $display("FAIL reentry_data: got %h required %h", obs_v[6], pack(1'b1, 8'hD0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5));
    end
  endtask

  task automatic test_reset_active;
    logic [7:0] seq [0:12];
    seq = '{8'h00, 8'h00, 8'h1D, 8'hA5, 8'h77, 8'h88, 8'h99, 8'h1D, 8'hA5, 8'h1D, 8'hA5, 8'h1D, 8'hA5};
    hs_settle_timeout = 8'd1;
    hs_sync_timeout = 8'd0;
    repeat (2) begin
      @(posedge clk); #1;
      hs_active = 1'b0;
    end
    for (int c = 0; c < 13; c++) begin
      @(posedge clk); #1;
      rst = c == 6;
      hs_active = 1'b1;
      hs_input = seq[c];
      @(negedge clk);
      if (c == 5) begin
        checks++;
        if (!(rx_active === 1'b1 && rx_valid === 1'b1 && rx_data === 8'hA5)) begin
          fails++;
          $display("FAIL rst_active_pre: got active=%b valid=%b data=%h required 1 1 a5", rx_active, rx_valid, rx_data);
        end
      end
      if (c == 7) begin
        checks++;
        if ({rx_data, rx_valid, rx_active, rx_start, rx_done, err_sync, align_offset} !== 16'h0000) begin
          fails++;
          $display("FAIL rst_active_clear: got %h required 0000",
                   {rx_data, rx_valid, rx_active, rx_start, rx_done, err_sync, align_offset});
        end
      end
      if (c > 7) begin
        checks++;
        if ({rx_valid, rx_active, rx_start, rx_done, err_sync} !== 5'b0) begin
          fails++;
          $display("FAIL rst_active_idle cycle %0d: got %b required 00000", c,
                   {rx_valid, rx_active, rx_start, rx_done, err_sync});
        end
      end
    end
    load_bytes(128'h00_00_1D_6B_00, 5);
    run_burst(1, 0, 5, 4);
    for (int c = 0; c < total; c++) begin
      checks++;
      if (obs_v[c] !== exp_v[c]) begin
        fails++;
        $display("FAIL rst_rearm cycle %0d: got %h expected %h", c, obs_v[c], exp_v[c]);
      end
    end
  endtask

  task automatic test_random;
    int n, t, l, p, k;
    logic [15:0] w;
    for (int it = 0; it < 40; it++) begin
      n = $urandom_range(0, 5);
      t = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(2, 12);
      l = $urandom_range(3, 40);
      for (int i = 0; i < l; i++) b[i] = 8'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        p = $urandom_range(2, l - 1);
        k = $urandom_range(0, 7);
        w = ({b[p], b[p-1]} & ~((16'd1 << (k + 8)) - 16'd1)) | (16'(SYNC) << k);
        b[p] = w[15:8];
        b[p-1] = w[7:0];
      end
      run_burst(n, t, l, 4);
      for (int c = 0; c < total; c++) begin
        checks++;
        if (obs_v[c] !== exp_v[c]) begin
          fails++;
          $display("FAIL random it=%0d n=%0d t=%0d l=%0d cycle %0d: got %h expected %h",
                   it, n, t, l, c, obs_v[c], exp_v[c]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    hs_active = 1'b0;
    hs_input = 8'h00;
    hs_settle_timeout = 8'd0;
    hs_sync_timeout = 8'd0;
    test_reset;
    test_offset0;
    test_offset3;
    test_settle_mask;
    test_sync_timeout;
    test_back_to_back;
    test_reset_active;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/dsi_hs_lane_rx.md
# dsi_hs_lane_rx

High-speed receive lane for the MIPI D-PHY data path, mirroring the HS transmit lane. It consumes the 8-bit deserialized byte stream of one data lane while the lane is in HS mode. After a settle period, it searches all 8 bit offsets for the HS sync byte, then locks to that offset and delivers realigned payload bytes to the packet layer. When HS mode ends it signals completion; trail bytes are forwarded untouched and the packet layer discards them by packet length.

## Interface
Parameters:
- SYNC_BYTE, 8'b00011101, HS sync sequence; bit 0 is first in time.

Ports:
- clk  input  1  serial byte clock
- rst  input  1  synchronous, active-high reset
- hs_input  input  8  deserialized lane byte; bit 0 is the earliest bit in time
- hs_active  input  1  high while the lane is in HS mode (from the LP state detector)
- hs_settle_timeout  input  8  cycles to ignore hs_input after HS entry
- hs_sync_timeout  input  8  max SEARCH cycles before error; 0 disables the timeout
- rx_data  output  8  realigned payload byte
- rx_valid  output  1  rx_data valid this cycle
- rx_active  output  1  high while locked (state ACTIVE)
- rx_start  output  1  one-cycle pulse on sync lock
- rx_done  output  1  one-cycle pulse when a locked burst ends
- err_sync  output  1  one-cycle pulse on sync search timeout
- align_offset  output  3  locked bit offset k

## Operation
- Reset: clk and rst only; synchronous and active-high. All outputs, prev_byte, the counter and the state go to 0/IDLE.
- prev_byte <= hs_input every cycle; cleared in IDLE.
- Window w = {hs_input, prev_byte}, 16 bits; bits 0..7 are the earlier byte.
- Sync match at offset k (0..7) requires both:
  - w[k+7:k] == SYNC_BYTE;
  - w[k-1:0] == 0 (always true for k=0).
- Given SYNC_BYTE bit 0 = 1, at most one k matches. No priority logic is required.
- States: IDLE, SETTLE, SEARCH, ACTIVE, WAIT_END.
  - IDLE: hs_active=1 -> SETTLE, and the counter loads max(hs_settle_timeout,1).
  - SETTLE: the counter decrements each cycle; no matching. At count 1 -> SEARCH, and the counter loads hs_sync_timeout.
  - SEARCH: evaluate the match every cycle.
    - Match -> ACTIVE; latch k into align_offset.
    - Otherwise, if hs_sync_timeout!=0 and the counter reaches 1 with no match -> WAIT_END with an err_sync pulse.
  - ACTIVE: each cycle register rx_data <= w[k+7:k] and rx_valid <= 1.
  - WAIT_END: outputs idle; wait for hs_active=0.
- hs_active=0 in any non-IDLE state -> IDLE next cycle. This has priority over match and timeout in the same cycle.
  - Leaving ACTIVE this way pulses rx_done.
  - Leaving SETTLE, SEARCH or WAIT_END this way produces no rx_done.
- Bursts without a sync never produce rx_valid.
- A sync pattern appearing inside payload is ignored (no relock while ACTIVE).

## Timing
- Sync detected in cycle n (SEARCH):
  - state=ACTIVE, rx_active=1, rx_start=1 and align_offset valid in n+1;
  - first rx_valid in n+2, carrying w(n+1)[k+7:k].
- In ACTIVE, rx_data/rx_valid in cycle m+1 reflect w(m). This is one register stage after the window is formed: a 2-cycle latency from hs_input for k=0.
- hs_active sampled low in cycle m while ACTIVE:
  - w(m) is not output;
  - rx_valid=0 and rx_active=0 from m+1;
  - rx_done=1 in m+1 only.
- err_sync asserts in the cycle after the last SEARCH cycle; rx_start, rx_done and err_sync are never high together.
- SETTLE duration is exactly max(hs_settle_timeout,1) cycles after the IDLE->SETTLE edge.
- rst high in any cycle: all outputs 0 on the next edge, no rx_done pulse. A new burst needs hs_active low->high.

## Test plan
- Offset 0: settle=2, sync_timeout=0, hs_active=1, bytes 00,00,00,1D,A5,3C,00 -> align_offset=0, rx_start once, then rx_valid with A5 followed by 3C.
- Offset 3: bytes 00,00,E8,28,05,00 -> lock on window {28,E8}, align_offset=3, first rx_data=A5, next 00.
- Settle masking: settle=4, 1D presented in the first settle cycle, then zeros -> no lock; a later 1D -> lock at offset 0.
- Sync timeout: sync_timeout=4, all-zero stream -> err_sync pulses once after 4 SEARCH cycles; no rx_valid; hs_active low -> IDLE with no rx_done.
- Burst end and reentry: drop hs_active mid-ACTIVE -> rx_done exactly one cycle, rx_valid low the next cycle; a second burst at offset 5 locks with align_offset=5.
- Reset in ACTIVE: rst=1 for one cycle -> all outputs 0 next cycle, no rx_done; the lane stays IDLE until hs_active toggles.
